// File: rtl/mainfsm.sv
// Main control FSM of the multicycle ARM controller.
// Moore machine: every datapath control is decoded from State alone.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       InstrDone,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_e;

  state_e state_q;
  state_e state_d;

  logic is_imm;
  logic is_load;

  assign is_imm  = Funct[5];
  assign is_load = Funct[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        unique case (Op)
          2'b00: state_d = is_imm ? EXECUTEI
                                  : EXECUTER;
          2'b01: state_d = MEMADR;
          2'b10: state_d = BRANCH;
          2'b11: state_d = UNKNOWN;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR: begin
        state_d = is_load ? MEMRD : MEMWR;
      end
      MEMRD: begin
        state_d = MEMWB;
      end
      EXECUTER: begin
        state_d = ALUWB;
      end
      EXECUTEI: begin
        state_d = ALUWB;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    InstrDone = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        NextPC    = 1'b1;
      end
      DECODE: begin
        // PC+8 is formed here for R15 reads
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB   = 2'b01;
      end
      MEMRD: begin
        AdrSrc    = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        MemW      = 1'b1;
        InstrDone = 1'b1;
      end
      EXECUTER: begin
        ALUOp     = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB   = 2'b01;
        ALUOp     = 1'b1;
      end
      ALUWB: begin
        RegW      = 1'b1;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        InstrDone = 1'b1;
      end
      default: begin
        // UNKNOWN and unreachable codes just retire
        InstrDone = 1'b1;
      end
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_mainfsm.sv
// Directed testbench for mainfsm.
// Walks each instruction class and checks State plus all controls.
module tb_mainfsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic       InstrDone;
  logic [3:0] State;

  int n_chk;
  int n_err;

  mainfsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .InstrDone (InstrDone),
    .State     (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,
  //  NextPC,RegW,MemW,Branch,ALUOp,InstrDone}
  logic [13:0] outs;
  assign outs = {IRWrite, AdrSrc, ALUSrcA,
                 ALUSrcB, ResultSrc, NextPC,
                 RegW, MemW, Branch, ALUOp,
                 InstrDone};

  function automatic logic [13:0] exp_outs(
    input logic [3:0] s
  );
    case (s)
      4'd0:  return 14'b1_0_01_10_10_1_0_0_0_0_0;
      4'd1:  return 14'b0_0_01_10_10_0_0_0_0_0_0;
      4'd2:  return 14'b0_0_00_01_00_0_0_0_0_0_0;
      4'd3:  return 14'b0_1_00_00_00_0_0_0_0_0_0;
      4'd4:  return 14'b0_0_00_00_01_0_1_0_0_0_1;
      4'd5:  return 14'b0_1_00_00_00_0_0_1_0_0_1;
      4'd6:  return 14'b0_0_00_00_00_0_0_0_0_1_0;
      4'd7:  return 14'b0_0_00_01_00_0_0_0_0_1_0;
      4'd8:  return 14'b0_0_00_00_00_0_1_0_0_0_1;
      4'd9:  return 14'b0_0_10_01_10_0_0_0_1_0_1;
      default: return 14'b0_0_00_00_00_0_0_0_0_0_1;
    endcase
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts sampled in FETCH; ends sampled in the next FETCH.
  task automatic run_seq(
    input string      name,
    input logic [1:0] op,
    input logic [5:0] f,
    input int         n,
    input logic [3:0] seq [6]
  );
    int done;
    done = 0;
    Op    = op;
    Funct = f;
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      chk($sformatf("%s st%0d", name, i),
          {28'd0, State}, {28'd0, seq[i]});
      chk($sformatf("%s out%0d", name, i),
          {18'd0, outs},
          {18'd0, exp_outs(seq[i])});
      if (i > 0 && InstrDone) done++;
    end
    chk($sformatf("%s done", name), done, 1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    Op    = 2'b00;
    Funct = 6'b000000;

    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst st%0d", i),
          {28'd0, State}, 32'd0);
      chk($sformatf("rst out%0d", i),
          {18'd0, outs},
          {18'd0, 14'b1_0_01_10_10_1_0_0_0_0_0});
    end
    reset = 1'b0;

    run_seq("dpr", 2'b00, 6'b000000, 5,
            '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd0});
    run_seq("ldr", 2'b01, 6'b011001, 6,
            '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0});
    run_seq("str", 2'b01, 6'b011000, 5,
            '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0});
    run_seq("addi", 2'b00, 6'b101000, 5,
            '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0, 4'd0});
    run_seq("dprs", 2'b00, 6'b000001, 5,
            '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd0});
    run_seq("b", 2'b10, 6'b000000, 4,
            '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0});
    run_seq("ill", 2'b11, 6'b111111, 4,
            '{4'd0, 4'd1, 4'd10, 4'd0, 4'd0, 4'd0});
    run_seq("ldri", 2'b01, 6'b111001, 6,
            '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0});

    // Abort a load in MEMRD
    Op    = 2'b01;
    Funct = 6'b011001;
    step();
    step();
    step();
    chk("abort pre", {28'd0, State}, 32'd3);
    reset = 1'b1;
    step();
    chk("abort st", {28'd0, State}, 32'd0);
    chk("abort regw", {31'd0, RegW}, 32'd0);
    reset = 1'b0;
    step();
    chk("abort nxt", {28'd0, State}, 32'd1);
    chk("abort regw2", {31'd0, RegW}, 32'd0);
    step();
    chk("abort mem", {28'd0, State}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
